// File: rtl/layer_sequencer.sv
// layer_sequencer: runs a table of conv-layer descriptors through IDP then CCM, ping-ponging feature-map regions.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   SEQ_START, SEQ_NUM_LAYERS         run request and layer count (sampled in IDLE)
//   DESC_WE, DESC_WADDR, DESC_WDATA   descriptor table write port (accepted in IDLE only)
//   SEQ_BUSY, SEQ_DONE, SEQ_ERR       run status; ERR is a sticky ack-timeout / bad-count flag
//   SEQ_LAYER                         current layer index
//   IDP_START/IDP_STATUS, CCM_START/CCM_STATUS   start pulses and busy levels of the two engines
//   CFG_*                             configuration of the current layer, registered in LOAD
module layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int LW = 3,
  parameter logic [31:0] BUF_A = 32'h0000_0000,
  parameter logic [31:0] BUF_B = 32'h0008_0000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SEQ_START,
  input  logic [LW:0]   SEQ_NUM_LAYERS,
  input  logic          DESC_WE,
  input  logic [LW-1:0] DESC_WADDR,
  input  logic [72:0]   DESC_WDATA,
  output logic          SEQ_BUSY,
  output logic          SEQ_DONE,
  output logic          SEQ_ERR,
  output logic [LW-1:0] SEQ_LAYER,
  output logic          IDP_START,
  output logic          CCM_START,
  input  logic          IDP_STATUS,
  input  logic          CCM_STATUS,
  output logic [31:0]   CFG_READ_START_ADDR,
  output logic [31:0]   CFG_WRITE_START_ADDR,
  output logic [8:0]    CFG_WIDTH,
  output logic [8:0]    CFG_HEIGHT,
  output logic [9:0]    CFG_NUM_FMAP,
  output logic [9:0]    CFG_NUM_KERNEL,
  output logic [31:0]   CFG_KERN_START_ADDR,
  output logic [2:0]    CFG_KERN_SIZE
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, IDP_GO, IDP_WAIT, CCM_GO, CCM_WAIT, NEXT, FIN} state_t;
  state_t state, state_nx;
  logic [72:0] tbl [MAX_LAYERS];
  logic [LW:0] num;
  logic side, armed, start_ok, last, status, waiting, timeout, ack_fall;
  logic [TW-1:0] cnt;
  always_comb begin
    start_ok = SEQ_NUM_LAYERS != '0 && SEQ_NUM_LAYERS <= (LW+1)'(MAX_LAYERS);
    last = {1'b0, SEQ_LAYER} == num - 1'b1;
    status = (state == IDP_GO || state == IDP_WAIT) ? IDP_STATUS : CCM_STATUS;
    waiting = state == IDP_WAIT || state == CCM_WAIT;
    // cnt counts cycles since the START pulse; giving up at ACK_TIMEOUT-1 puts FIN exactly ACK_TIMEOUT cycles after it
    timeout = waiting && !armed && !status && cnt == TW'(ACK_TIMEOUT - 1);
    ack_fall = waiting && armed && !status;
    SEQ_BUSY = state != IDLE && state != FIN;
    SEQ_DONE = state == FIN;
    IDP_START = state == IDP_GO;
    CCM_START = state == CCM_GO;
    state_nx = state;
    case (state)
      IDLE:     if (SEQ_START) state_nx = start_ok ? LOAD : FIN;
      LOAD:     state_nx = IDP_GO;
      IDP_GO:   state_nx = IDP_WAIT;
      IDP_WAIT: state_nx = timeout ? FIN : ack_fall ? CCM_GO : IDP_WAIT;
      CCM_GO:   state_nx = CCM_WAIT;
      CCM_WAIT: state_nx = timeout ? FIN : ack_fall ? NEXT : CCM_WAIT;
      NEXT:     state_nx = last ? FIN : LOAD;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (DESC_WE && state == IDLE) tbl[DESC_WADDR] <= DESC_WDATA;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SEQ_ERR <= 1'b0;
      SEQ_LAYER <= '0;
      num <= '0;
      side <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      CFG_READ_START_ADDR <= '0;
      CFG_WRITE_START_ADDR <= '0;
      {CFG_WIDTH, CFG_HEIGHT, CFG_NUM_FMAP, CFG_NUM_KERNEL, CFG_KERN_SIZE, CFG_KERN_START_ADDR} <= '0;
    end else begin
      if (state == IDLE && SEQ_START) begin
        SEQ_ERR <= !start_ok;
        num <= SEQ_NUM_LAYERS;
        SEQ_LAYER <= '0;
        side <= 1'b0;
      end
      if (state == LOAD) begin
        {CFG_WIDTH, CFG_HEIGHT, CFG_NUM_FMAP, CFG_NUM_KERNEL, CFG_KERN_SIZE, CFG_KERN_START_ADDR} <= tbl[SEQ_LAYER];
        CFG_READ_START_ADDR <= side ? BUF_B : BUF_A;
        CFG_WRITE_START_ADDR <= side ? BUF_A : BUF_B;
      end
      // a STATUS already high at the START pulse counts as the acknowledge
      if (state == IDP_GO || state == CCM_GO) begin
        armed <= status;
        cnt <= TW'(1);
      end
      if (waiting) begin
        armed <= armed | status;
        cnt <= cnt + 1'b1;
      end
      if (timeout) SEQ_ERR <= 1'b1;
      if (state == NEXT && !last) begin
        SEQ_LAYER <= SEQ_LAYER + 1'b1;
        side <= !side;
      end
    end
  end
endmodule
